// File: rtl/freq_div_prog.sv
// Programmable carrier divider: half-period picked by a select code, glitch-free divisor
// changes at terminal count, square or pulse output. Optional cycle counter: FREQ_DIV_CYC_CNT_EN.
module freq_div_prog #(
    parameter int CNT_W = 9,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             init,
    input  logic [SEL_W-1:0] cnt,
    input  logic             mode,
    output logic             freq_div_out,
    output logic             tick,
    output logic             pending
`ifdef FREQ_DIV_CYC_CNT_EN
    ,
    output logic [15:0]      cyc_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] ctr;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] shadow;
    logic [SEL_W-1:0] next_sel;
    logic             tc;

    // Counting up from this value to all-ones takes 2^CNT_W - load_val cycles.
    function automatic logic [CNT_W-1:0] load_val(input logic [SEL_W-1:0] s);
        return {1'b1, s, {(CNT_W-1-SEL_W){1'b0}}};
    endfunction

    // An init landing on the terminal count bypasses the shadow register.
    always_comb begin
        tc       = (state == RUN) && en && (ctr == '1);
        next_sel = sel_q;
        if (init)
            next_sel = cnt;
        else if (pending)
            next_sel = shadow;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ctr          <= '0;
            sel_q        <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            tick         <= 1'b0;
            freq_div_out <= 1'b0;
`ifdef FREQ_DIV_CYC_CNT_EN
            cyc_cnt      <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tick         <= 1'b0;
                    freq_div_out <= 1'b0;
                    pending      <= 1'b0;
                    if (init) begin
                        ctr   <= load_val(cnt);
                        sel_q <= cnt;
                        state <= RUN;
`ifdef FREQ_DIV_CYC_CNT_EN
                        cyc_cnt <= 16'd0;
`endif
                    end
                end
                RUN: begin
                    tick <= tc;
                    if (tc) begin
                        ctr          <= load_val(next_sel);
                        sel_q        <= next_sel;
                        pending      <= 1'b0;
                        freq_div_out <= mode ? 1'b1 : ~freq_div_out;
`ifdef FREQ_DIV_CYC_CNT_EN
                        cyc_cnt      <= cyc_cnt + 16'd1;
`endif
                    end else begin
                        if (en) begin
                            ctr          <= ctr + CNT_W'(1);
                            freq_div_out <= mode ? 1'b0 : freq_div_out;
                        end
                        if (init) begin
                            shadow  <= cnt;
                            pending <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_div_prog.sv
// Scoreboard bench for freq_div_prog: predicted tick cycles/outputs are queued at stimulus
// time and matched against ticks captured by a monitor.
module tb_freq_div_prog;

    localparam int CNT_W = 9;
    localparam int SEL_W = 3;

    logic             clk;
    logic             rst;
    logic             en;
    logic             init;
    logic [SEL_W-1:0] cnt;
    logic             mode;
    logic             freq_div_out;
    logic             tick;
    logic             pending;
`ifdef FREQ_DIV_CYC_CNT_EN
    logic [15:0]      cyc_cnt;
`endif

    freq_div_prog #(.CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .init         (init),
        .cnt          (cnt),
        .mode         (mode),
        .freq_div_out (freq_div_out),
        .tick         (tick),
        .pending      (pending)
`ifdef FREQ_DIV_CYC_CNT_EN
        ,
        .cyc_cnt      (cyc_cnt)
`endif
    );

    typedef struct {
        int   c;
        logic o;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  obs_rd = 0;
    int  cyc    = 0;
    int  n_vec  = 0;
    int  n_err  = 0;
    int  last_t = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every tick seen is logged with its edge number and the output level at that time.
    always @(negedge clk)
        if (tick === 1'b1) obs_q.push_back('{c: cyc, o: freq_div_out});

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got t=%0t want finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic goto(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic pulse_init(input logic [SEL_W-1:0] s);
        init = 1'b1;
        cnt  = s;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic get_obs(input int budget, output bit ok, output ev_t ev);
        ok = 1'b0;
        ev = '{c: 0, o: 1'b0};
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() > obs_rd) begin
                ok = 1'b1;
                ev = obs_q[obs_rd];
                obs_rd++;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; init = 1'b0; cnt = '0; mode = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (freq_div_out !== 1'b0) begin n_err++; $display("FAIL rst_out: got %b want 0", freq_div_out); end
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b want 0", tick); end
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", pending); end
`ifdef FREQ_DIV_CYC_CNT_EN
        n_vec++; if (cyc_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cyc_cnt: got %0d want 0", cyc_cnt); end
`endif
        rst = 1'b1;
        en  = 1'b1;
        repeat (20) @(negedge clk);
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL idle_no_tick: got %0d ticks want 0", obs_q.size()); end
    endtask

    task automatic test_square();
        int e; bit ok; ev_t ev; ev_t want;
        obs_rd = obs_q.size();
        exp_q.delete();
        @(negedge clk);
        mode = 1'b0; en = 1'b1;
        e = cyc + 1;
        pulse_init(3'd4);
        for (int i = 1; i <= 3; i++) exp_q.push_back('{c: e + 128 * i, o: (i % 2 == 1)});
        for (int i = 0; i < 3; i++) begin
            get_obs(300, ok, ev);
            want = exp_q.pop_front();
            n_vec++;
            if (!ok) begin
                n_err++; $display("FAIL sq_tick%0d: got no tick want cyc=%0d", i, want.c);
            end else if (ev.c !== want.c || ev.o !== want.o) begin
                n_err++; $display("FAIL sq_tick%0d: got cyc=%0d out=%b want cyc=%0d out=%b", i, ev.c, ev.o, want.c, want.o);
            end
        end
        last_t = e + 384;
    endtask

    task automatic test_switch();
        int t; bit ok; ev_t ev; ev_t want;
        t = last_t;
        obs_rd = obs_q.size();
        exp_q.delete();
        goto(t + 39);
        pulse_init(3'd7);
        n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL sw_pend_set: got %b want 1", pending); end
        goto(t + 127);
        n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL sw_pend_hold: got %b want 1", pending); end
        goto(t + 128);
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL sw_pend_clr: got %b want 0", pending); end
        exp_q.push_back('{c: t + 128, o: 1'b0});
        exp_q.push_back('{c: t + 160, o: 1'b1});
        exp_q.push_back('{c: t + 192, o: 1'b0});
        for (int i = 0; i < 3; i++) begin
            get_obs(300, ok, ev);
            want = exp_q.pop_front();
            n_vec++;
            if (!ok) begin
                n_err++; $display("FAIL sw_tick%0d: got no tick want cyc=%0d", i, want.c);
            end else if (ev.c !== want.c || ev.o !== want.o) begin
                n_err++; $display("FAIL sw_tick%0d: got cyc=%0d out=%b want cyc=%0d out=%b", i, ev.c, ev.o, want.c, want.o);
            end
        end
        last_t = t + 192;
    endtask

    task automatic test_back_to_back();
        int t; bit ok; ev_t ev; ev_t want;
        t = last_t;
        obs_rd = obs_q.size();
        exp_q.delete();
        goto(t + 31);
        pulse_init(3'd0);
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL tcinit_pend: got %b want 0", pending); end
        goto(t + 33);
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL tcinit_pend2: got %b want 0", pending); end
        exp_q.push_back('{c: t + 32, o: 1'b1});
        exp_q.push_back('{c: t + 288, o: 1'b0});
        for (int i = 0; i < 2; i++) begin
            get_obs(300, ok, ev);
            want = exp_q.pop_front();
            n_vec++;
            if (!ok) begin
                n_err++; $display("FAIL tcinit_tick%0d: got no tick want cyc=%0d", i, want.c);
            end else if (ev.c !== want.c || ev.o !== want.o) begin
                n_err++; $display("FAIL tcinit_tick%0d: got cyc=%0d out=%b want cyc=%0d out=%b", i, ev.c, ev.o, want.c, want.o);
            end
        end
        last_t = t + 288;
    endtask

    task automatic test_pulse_freeze();
        int e; bit ok; ev_t ev; ev_t want; logic w;
        @(negedge clk); rst = 1'b0; en = 1'b1; mode = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        obs_rd = obs_q.size();
        exp_q.delete();
        e = cyc + 1;
        pulse_init(3'd7);
        exp_q.push_back('{c: e + 32,  o: 1'b1});
        exp_q.push_back('{c: e + 64,  o: 1'b1});
        exp_q.push_back('{c: e + 106, o: 1'b1});
        exp_q.push_back('{c: e + 138, o: 1'b1});
        for (int c = e + 1; c <= e + 138; c++) begin
            goto(c);
            w = (c == e + 32) || (c == e + 64) || (c == e + 106) || (c == e + 138);
            n_vec++;
            if (freq_div_out !== w || tick !== w) begin
                n_err++; $display("FAIL pulse_cyc%0d: got out=%b tick=%b want %b", c - e, freq_div_out, tick, w);
            end
            if (c == e + 74) en = 1'b0;
            if (c == e + 84) en = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            get_obs(100, ok, ev);
            want = exp_q.pop_front();
            n_vec++;
            if (!ok) begin
                n_err++; $display("FAIL pulse_tick%0d: got no tick want cyc=%0d", i, want.c);
            end else if (ev.c !== want.c || ev.o !== want.o) begin
                n_err++; $display("FAIL pulse_tick%0d: got cyc=%0d out=%b want cyc=%0d out=%b", i, ev.c, ev.o, want.c, want.o);
            end
        end
    endtask

    task automatic test_async_reset();
        int e;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1; mode = 1'b1; en = 1'b1;
        @(negedge clk);
        e = cyc + 1;
        pulse_init(3'd7);
        goto(e + 32);
        n_vec++; if (tick !== 1'b1 || freq_div_out !== 1'b1) begin n_err++; $display("FAIL ar_pre: got tick=%b out=%b want 1 1", tick, freq_div_out); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL ar_tick: got %b want 0", tick); end
        n_vec++; if (freq_div_out !== 1'b0) begin n_err++; $display("FAIL ar_out: got %b want 0", freq_div_out); end
        @(negedge clk); rst = 1'b1; mode = 1'b0;
        @(negedge clk);
        e = cyc + 1;
        pulse_init(3'd7);
        pulse_init(3'd4);
        n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL ar_pend_pre: got %b want 1", pending); end
        goto(e + 10);
        #2 rst = 1'b0;
        #1;
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL ar_pend: got %b want 0", pending); end
        n_vec++; if (tick !== 1'b0 || freq_div_out !== 1'b0) begin n_err++; $display("FAIL ar_outs: got tick=%b out=%b want 0 0", tick, freq_div_out); end
        @(negedge clk); rst = 1'b1; en = 1'b1;
        obs_rd = obs_q.size();
        repeat (300) @(negedge clk);
        n_vec++;
        if (obs_q.size() != obs_rd) begin n_err++; $display("FAIL ar_no_tick: got %0d ticks want 0", obs_q.size() - obs_rd); end
    endtask

`ifdef FREQ_DIV_CYC_CNT_EN
    task automatic test_cyc_cnt();
        int e;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1; mode = 1'b0; en = 1'b1;
        @(negedge clk);
        e = cyc + 1;
        pulse_init(3'd7);
        n_vec++; if (cyc_cnt !== 16'd0) begin n_err++; $display("FAIL cc_load: got %0d want 0", cyc_cnt); end
        goto(e + 3199);
        n_vec++; if (cyc_cnt !== 16'd99) begin n_err++; $display("FAIL cc_99: got %0d want 99", cyc_cnt); end
        goto(e + 3200);
        n_vec++; if (cyc_cnt !== 16'd100) begin n_err++; $display("FAIL cc_100: got %0d want 100", cyc_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_square();
        test_switch();
        test_back_to_back();
        test_pulse_freeze();
        test_async_reset();
`ifdef FREQ_DIV_CYC_CNT_EN
        test_cyc_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/freq_div_prog.md
Name: freq_div_prog

Overview:
Parametrised programmable frequency divider for the digital-modulation datapath (FSK/ASK carrier generation). A selected divisor code sets the half-period. Divisor changes requested mid-run are applied only at the next terminal count, so the carrier switches frequency without phase glitches. Square-wave or single-pulse output is selectable at run time. It is the CNT_W/SEL_W-generic successor of the fixed 9-bit/3-bit divider.

Parameters:
CNT_W, 9, counter width; must satisfy CNT_W >= SEL_W+2
SEL_W, 3, divisor select code width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
en  in  1  count enable; 0 freezes counter and outputs
init  in  1  one-cycle load strobe for cnt
cnt  in  SEL_W  divisor select code
mode  in  1  0 = square (toggle), 1 = pulse
freq_div_out  out  1  divided clock output, registered
tick  out  1  one-cycle terminal-count strobe, registered
pending  out  1  a divisor change is queued, not yet applied

Behaviour:
- Load value L(s) = {1'b1, s, (CNT_W-1-SEL_W) zeros}, CNT_W bits. Half-period H(s) = 2^CNT_W - L(s).
- For CNT_W=9, SEL_W=3: H = 256 - 32*s, so s=0 gives 256, s=4 gives 128, s=7 gives 32.
- Terminal count: tc = (state==RUN) && en && (ctr == all-ones).
- Reset (rst=0, asynchronous, at any time including mid-run):
  - state=IDLE; ctr, sel_q, shadow all 0.
  - freq_div_out=0, tick=0, pending=0.
- IDLE:
  - Counter holds; outputs stay 0.
  - init=1 at an edge: ctr<=L(cnt), sel_q<=cnt, state<=RUN. This is independent of en.
- RUN, en=1: ctr increments by 1 each cycle. At tc, ctr reloads with L(next_sel); there is no wrap to 0.
  - next_sel = shadow if pending=1, otherwise sel_q.
  - At that edge sel_q<=next_sel and pending<=0.
- RUN, en=0: ctr, freq_div_out and pending hold; tick=0. init is still accepted into shadow.
- init in RUN: shadow<=cnt, pending<=1.
  - If init coincides with tc, cnt is used directly for that reload and pending stays 0.
  - A second init before the reload overwrites shadow; last write wins.
- Timing: the first tick is high exactly H cycles after the loading edge. Tick period is H(sel_q) while en=1.
- tick <= tc; it is high for exactly one cycle.
- freq_div_out next-state:
  - tc and mode=0: invert (period 2H, 50% duty).
  - tc and mode=1: 1.
  - no tc and mode=0: hold.
  - no tc and mode=1: 0. In pulse mode the output mirrors tick.
- mode is a level input; a change takes effect on the next edge per the rules above. No reset of ctr on a mode change.
- Out-of-range codes do not exist; every SEL_W code is a legal divisor.

Optional Feature:
FREQ_DIV_CYC_CNT_EN
- Defined: adds output port cyc_cnt, 16 bits.
  - Increments on every tc and wraps from 0xFFFF to 0.
  - Cleared by reset and by the IDLE-to-RUN load.
  - Holds while en=0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then init with cnt=4, mode=0, en=1 -> tick every 128 cycles; freq_div_out period 256 cycles, 50% duty; first tick 128 cycles after the init edge.
- Running at cnt=4, init cnt=7 at cycle 40 of the half-period -> pending=1 until the tc at cycle 128; then ticks every 32 cycles, freq_div_out continuous with no short pulse.
- init cnt=0 on the same cycle as tc -> pending stays 0; next tick exactly 256 cycles later.
- mode=1, cnt=7 -> freq_div_out high 1 cycle every 32 cycles, identical to tick. en=0 for 10 cycles mid-count -> next tick delayed by exactly 10 cycles.
- rst=0 asserted asynchronously mid-half-period -> freq_div_out, tick, pending at 0 immediately; no ticks until a fresh init, even with en=1.
- With FREQ_DIV_CYC_CNT_EN, cnt=7, 100 ticks -> cyc_cnt=100; wraps to 0 after 65536 ticks.
